// File: rtl/ff_chk_pkg.sv
// Shared types and default constants for the FF response checker.
// Holds the FSM state type and the default MISR polynomial, seed and width.
package ff_chk_pkg;

  localparam int          WIDTH_DEF = 12;
  localparam logic [11:0] POLY_DEF  = 12'h053;  // x^12+x^6+x^4+x+1
  localparam logic [11:0] SEED_DEF  = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: a shift register with polynomial feedback
// and the observed word XORed in on every enabled cycle.
module misr_reg
  import ff_chk_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY  = POLY_DEF,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
  end

  // The reset value is a constant so that an aborted window always restarts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= SEED;
    end else if (load) begin
      sig_q <= seed;
    end else if (shift_en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ff_resp_checker.sv
// Compresses observed FF outputs into a MISR signature over a programmable window
// and reports pass/fail. Define FF_RESP_CHECKER_TIMEOUT_EN to add an idle timeout.
module ff_resp_checker
  import ff_chk_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEF,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = POLY_DEF,
  parameter logic [WIDTH-1:0] SEED  = SEED_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] obs,
  input  logic             obs_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
  , output logic           timeout
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] exp_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             misr_load;
  logic             misr_shift;

  assign misr_load  = (state_q == IDLE) && start;
  assign misr_shift = (state_q == RUN) && obs_valid;

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .reset    (reset),
    .load     (misr_load),
    .seed     (SEED),
    .shift_en (misr_shift),
    .din      (obs),
    .sig      (signature)
  );

`ifdef FF_RESP_CHECKER_TIMEOUT_EN
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] idle_inc;
  logic             timeout_q;

  assign idle_inc = idle_q + CNT_W'(1);
  assign timeout  = timeout_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      exp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q  <= expected;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
            // An empty window goes straight to the compare against the seed.
            if (len != '0) begin
              count_q <= len;
              state_q <= RUN;
            end else begin
              state_q <= CHECK;
            end
          end
        end
        RUN: begin
          if (obs_valid) begin
            count_q <= count_q - CNT_W'(1);
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
            idle_q  <= '0;
`endif
            if (count_q == CNT_W'(1)) begin
              state_q <= CHECK;
            end
          end
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
          else begin
            idle_q <= idle_inc;
            if (idle_inc == '1) begin
              timeout_q <= 1'b1;
              state_q   <= CHECK;
            end
          end
`endif
        end
        CHECK: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
          pass_q  <= (signature == exp_q) && !timeout_q;
`else
          pass_q  <= (signature == exp_q);
`endif
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_ff_resp_checker.sv
// Randomized self-checking bench for ff_resp_checker against a queue-based
// signature model; also covers directed edge cases and mid-window reset.
module tb_ff_resp_checker;

  localparam int          WIDTH = 12;
  localparam int          CNT_W = 8;
  localparam logic [11:0] POLY  = 12'h053;
  localparam logic [11:0] SEED  = 12'h000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [WIDTH-1:0] expected = '0;
  logic [WIDTH-1:0] obs = '0;
  logic             obs_valid = 1'b0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
  logic             timeout;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] samp_q[$];
  int               gap_q[$];

  ff_resp_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .expected  (expected),
    .obs       (obs),
    .obs_valid (obs_valid),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: multiply-by-x modulo the polynomial, then add the observed word.
  function automatic logic [11:0] misr_step(input logic [11:0] s, input logic [11:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= 4096) v = (v - 4096) ^ int'(POLY);
    return 12'(v) ^ d;
  endfunction

  function automatic logic [11:0] model_sig();
    logic [11:0] s;
    s = SEED;
    foreach (samp_q[i]) s = misr_step(s, samp_q[i]);
    return s;
  endfunction

  // Runs one window using samp_q (samples) and gap_q (idle cycles before each sample).
  task automatic run_window(input logic [11:0] exp_v, input bit noise);
    logic [11:0] s;
    int n;
    n = samp_q.size();
    s = SEED;
    start = 1'b1; len = CNT_W'(n); expected = exp_v;
    tick();
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        obs_valid = 1'b0;
        obs = 12'($urandom);
        if (noise) begin
          start = 1'($urandom_range(0, 1)); len = 8'($urandom); expected = 12'($urandom);
        end
        tick();
        check_val("busy_gap", busy, 1);
        check_val("done_gap", done, 0);
      end
      start = 1'b0;
      obs_valid = 1'b1;
      obs = samp_q[i];
      s = misr_step(s, samp_q[i]);
      tick();
      obs_valid = 1'b0;
      obs = 12'($urandom);
      if (i < n - 1) check_val("sig_mid", signature, s);
    end
    check_val("done_early", done, 0);
    tick();
    check_val("done", done, 1);
    check_val("sig_final", signature, s);
    check_val("pass", pass, (s == exp_v));
    check_val("busy_end", busy, 0);
    tick();
    check_val("done_pulse", done, 0);
    check_val("pass_hold", pass, (s == exp_v));
  endtask

  initial begin
    #2;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_sig", signature, SEED);
    @(negedge clk); reset = 1'b1;
    tick();

    // Single sample.
    samp_q = '{12'h0A5}; gap_q = '{0};
    run_window(12'h0A5, 1'b0);

    // MSB feedback, back-to-back.
    samp_q = '{12'h800, 12'h001}; gap_q = '{0, 0};
    run_window(12'h052, 1'b0);

    // Mismatch with a 3-cycle gap and ignored start requests.
    samp_q = '{12'h800, 12'h001}; gap_q = '{0, 3};
    run_window(12'h053, 1'b1);

    // Empty window: done two cycles after start.
    start = 1'b1; len = '0; expected = 12'h000;
    tick();
    start = 1'b0;
    check_val("empty_busy", busy, 1);
    check_val("empty_early", done, 0);
    tick();
    check_val("empty_done", done, 1);
    check_val("empty_pass", pass, 1);

    // Reset in the middle of a window.
    tick();
    start = 1'b1; len = 8'd4; expected = 12'h123;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs_valid = 1'b1; obs = 12'($urandom | 1);
      tick();
    end
    obs_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_sig", signature, SEED);
    check_val("mid_rst_pass", pass, 0);
    @(negedge clk); reset = 1'b1;
    tick();
    samp_q = '{12'h0A5}; gap_q = '{0};
    run_window(12'h0A5, 1'b0);

    // Randomized windows.
    for (int w = 0; w < 25; w++) begin
      int n;
      logic [11:0] ref_sig;
      n = $urandom_range(1, 9);
      samp_q.delete(); gap_q.delete();
      for (int i = 0; i < n; i++) begin
        samp_q.push_back(12'($urandom));
        gap_q.push_back($urandom_range(0, 3));
      end
      ref_sig = model_sig();
      run_window(($urandom_range(0, 1) != 0) ? ref_sig : 12'($urandom), 1'b1);
    end

    // Stalled window.
    start = 1'b1; len = 8'd3; expected = 12'h0A5;
    tick();
    start = 1'b0;
    obs_valid = 1'b1; obs = 12'h0A5;
    tick();
    obs_valid = 1'b0;
`ifdef FF_RESP_CHECKER_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check_val("tmo_done_seen", seen, 1);
      check_val("tmo_pass", pass, 0);
      check_val("tmo_flag", timeout, 1);
    end
`else
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check_val("stall_no_done", seen, 0);
      check_val("stall_busy", busy, 1);
      obs_valid = 1'b1; obs = 12'h001;
      tick();
      tick();
      obs_valid = 1'b0;
      tick();
      check_val("stall_done", done, 1);
      check_val("stall_sig", signature,
                misr_step(misr_step(misr_step(SEED, 12'h0A5), 12'h001), 12'h001));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
